// File: rtl/serial_sub_pkg.sv
// Shared state encoding and width helpers for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Bit-counter width: enough to count WIDTH bits, never narrower than one bit.
    function automatic int calc_cnt_w(input int width);
        int w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bi, borrow out on bo.
module full_subtractor (
    output logic d,
    output logic bo,
    input  logic a,
    input  logic b,
    input  logic bi
);

    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full_subtractor cell, one bit per clock, LSB first,
// with valid/ready handshakes on the operand and result sides.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bo,
    output logic             busy
);

    localparam int              CNT_W    = calc_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e             state_r;
    state_e             state_s;
    logic [WIDTH-1:0]   a_sh_r;
    logic [WIDTH-1:0]   b_sh_r;
    logic [WIDTH-1:0]   diff_sh_r;
    logic [WIDTH-1:0]   diff_sh_s;
    logic [WIDTH-1:0]   diff_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               br_r;
    logic               bo_r;
    logic               d_s;
    logic               bo_cell_s;
    logic               last_s;

    full_subtractor u_cell (
        .d  (d_s),
        .bo (bo_cell_s),
        .a  (a_sh_r[0]),
        .b  (b_sh_r[0]),
        .bi (br_r)
    );

    // Next-state decode for the IDLE -> SHIFT -> DONE sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) state_s = SHIFT;
                else          state_s = IDLE;
            end
            SHIFT: begin
                if (last_s) state_s = DONE;
                else        state_s = SHIFT;
            end
            DONE: begin
                if (out_ready) state_s = IDLE;
                else           state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // Next result shift value (new difference bit enters at the MSB) and last-bit detect.
    always_comb begin
        diff_sh_s            = diff_sh_r >> 1;
        diff_sh_s[WIDTH-1]   = d_s;
        last_s               = (cnt_r == LAST_CNT);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_s;
    end

    // Operand capture, bit-serial shifting and result latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_r    <= {WIDTH{1'b0}};
            b_sh_r    <= {WIDTH{1'b0}};
            diff_sh_r <= {WIDTH{1'b0}};
            diff_r    <= {WIDTH{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            br_r      <= 1'b0;
            bo_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_r <= a;
                        b_sh_r <= b;
                        br_r   <= bi;
                        cnt_r  <= {CNT_W{1'b0}};
                    end
                end
                SHIFT: begin
                    a_sh_r    <= a_sh_r >> 1;
                    b_sh_r    <= b_sh_r >> 1;
                    br_r      <= bo_cell_s;
                    diff_sh_r <= diff_sh_s;
                    cnt_r     <= cnt_r + CNT_W'(1);
                    if (last_s) begin
                        diff_r <= diff_sh_s;
                        bo_r   <= bo_cell_s;
                    end
                end
                default: begin
                    // DONE holds the presented result until the consumer takes it.
                end
            endcase
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign busy      = (state_r == SHIFT) || (state_r == DONE);
    assign diff      = diff_r;
    assign bo        = bo_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: three subtractor instances (WIDTH 4, 1, 8) against a
// transaction-level model of A - B - bi with handshake timing.
module tb_serial_subtractor;

    localparam int NDUT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid_v  [NDUT];
    logic       out_ready_v [NDUT];
    logic [7:0] a_v         [NDUT];
    logic [7:0] b_v         [NDUT];
    logic       bi_v        [NDUT];
    wire        in_ready_v  [NDUT];
    wire        out_valid_v [NDUT];
    wire        bo_v        [NDUT];
    wire        busy_v      [NDUT];
    wire  [7:0] diff_v      [NDUT];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    function automatic int wid(input int g);
        return (g == 0) ? 4 : ((g == 1) ? 1 : 8);
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int W = (g == 0) ? 4 : ((g == 1) ? 1 : 8);
        logic [W-1:0] diff_w;
        serial_subtractor #(.WIDTH(W)) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid_v[g]),
            .in_ready  (in_ready_v[g]),
            .a         (a_v[g][W-1:0]),
            .b         (b_v[g][W-1:0]),
            .bi        (bi_v[g]),
            .out_valid (out_valid_v[g]),
            .out_ready (out_ready_v[g]),
            .diff      (diff_w),
            .bo        (bo_v[g]),
            .busy      (busy_v[g])
        );
        assign diff_v[g] = 8'(diff_w);
    end

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // {bo,diff} = ({1'b0,a} - b - bi) mod 2^(w+1)
    function automatic int model_sub(input int w, input logic [7:0] a, input logic [7:0] b, input logic bi);
        int am, bm, r;
        am = int'(a) & ((1 << w) - 1);
        bm = int'(b) & ((1 << w) - 1);
        r  = am - bm - int'(bi);
        return r & ((1 << (w + 1)) - 1);
    endfunction

    task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d: got %0d expected %0d (t=%0t)", name, g, act, exp, $time);
        end
    endtask

    // Transaction model: result appears W edges after accept, held until taken.
    bit idle_m [NDUT];
    bit outv_m [NDUT];
    int rem_m  [NDUT];
    int res_m  [NDUT];

    always @(posedge clk or posedge rst) begin
        for (int g = 0; g < NDUT; g++) begin
            if (rst) begin
                idle_m[g] <= 1'b1;
                outv_m[g] <= 1'b0;
                rem_m[g]  <= 0;
            end else if (idle_m[g]) begin
                if (in_valid_v[g] === 1'b1) begin
                    res_m[g]  <= model_sub(wid(g), a_v[g], b_v[g], bi_v[g]);
                    idle_m[g] <= 1'b0;
                    rem_m[g]  <= wid(g);
                end
            end else if (rem_m[g] > 0) begin
                if (rem_m[g] == 1) outv_m[g] <= 1'b1;
                rem_m[g] <= rem_m[g] - 1;
            end else if (out_ready_v[g] === 1'b1) begin
                outv_m[g] <= 1'b0;
                idle_m[g] <= 1'b1;
            end
        end
    end

    // Every-cycle comparison of all instances against the model.
    always @(negedge clk) begin
        if (!rst) begin
            for (int g = 0; g < NDUT; g++) begin
                check("in_ready",  g, 32'(in_ready_v[g]),  32'(idle_m[g]));
                check("out_valid", g, 32'(out_valid_v[g]), 32'(outv_m[g]));
                check("busy",      g, 32'(busy_v[g]),      32'(!idle_m[g]));
                if (outv_m[g]) begin
                    check("diff", g, 32'(diff_v[g]), 32'(res_m[g] & ((1 << wid(g)) - 1)));
                    check("bo",   g, 32'(bo_v[g]),   32'((res_m[g] >> wid(g)) & 1));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int g, input logic [7:0] a, input logic [7:0] b, input logic bi,
                        input bit keep, output int acc_cyc);
        int n;
        n = 0;
        a_v[g] = a; b_v[g] = b; bi_v[g] = bi;
        in_valid_v[g] = 1'b1;
        while (in_ready_v[g] !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        check("accept_wait", g, 32'(n < 100), 32'd1);
        step();
        acc_cyc = cyc;
        if (!keep) in_valid_v[g] = 1'b0;
    endtask

    task automatic wait_out(input int g, output int seen_cyc);
        int n;
        n = 0;
        while (out_valid_v[g] !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        check("result_wait", g, 32'(n < 100), 32'd1);
        seen_cyc = cyc;
    endtask

    task automatic directed(input int g, input logic [7:0] a, input logic [7:0] b, input logic bi,
                            input int ed, input int eb, input string name);
        int acc, seen;
        send(g, a, b, bi, 1'b0, acc);
        wait_out(g, seen);
        check({name, "_latency"}, g, 32'(seen - acc), 32'(wid(g)));
        check({name, "_diff"}, g, 32'(diff_v[g]), 32'(ed));
        check({name, "_bo"},   g, 32'(bo_v[g]),   32'(eb));
        step();
    endtask

    task automatic sweep(input int g, input int n);
        int  acc, m;
        bit  done;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) step();
            send(g, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0, acc);
            m = 0;
            done = 1'b0;
            while (!done && m < 200) begin
                out_ready_v[g] = 1'($urandom_range(0, 1));
                done = (out_valid_v[g] === 1'b1) && out_ready_v[g];
                step();
                m++;
            end
            check("handshake_wait", g, 32'(done), 32'd1);
            out_ready_v[g] = 1'b1;
        end
    endtask

    initial begin
        int acc, prev;
        for (int g = 0; g < NDUT; g++) begin
            in_valid_v[g]  = 1'b0;
            out_ready_v[g] = 1'b1;
            a_v[g] = 8'd0; b_v[g] = 8'd0; bi_v[g] = 1'b0;
        end
        rst = 1'b1;
        step();
        step();
        for (int g = 0; g < NDUT; g++) begin
            check("rst_in_ready",  g, 32'(in_ready_v[g]),  32'd1);
            check("rst_out_valid", g, 32'(out_valid_v[g]), 32'd0);
            check("rst_diff",      g, 32'(diff_v[g]),      32'd0);
            check("rst_bo",        g, 32'(bo_v[g]),        32'd0);
            check("rst_busy",      g, 32'(busy_v[g]),      32'd0);
        end
        rst = 1'b0;

        check("model_9_3",   0, 32'(model_sub(4, 8'd9, 8'd3, 1'b0)), 32'h06);
        check("model_3_9",   0, 32'(model_sub(4, 8'd3, 8'd9, 1'b0)), 32'h1A);
        check("model_0_0_1", 0, 32'(model_sub(4, 8'd0, 8'd0, 1'b1)), 32'h1F);
        check("model_w1",    1, 32'(model_sub(1, 8'd1, 8'd1, 1'b1)), 32'h3);

        directed(0, 8'd9, 8'd3, 1'b0, 6, 0, "sub_9_3");
        directed(0, 8'd3, 8'd9, 1'b0, 10, 1, "sub_3_9");
        directed(0, 8'd0, 8'd0, 1'b1, 15, 1, "sub_0_0_1");

        // Back-pressure: result must hold while the consumer stalls.
        out_ready_v[0] = 1'b0;
        send(0, 8'd15, 8'd15, 1'b0, 1'b0, acc);
        wait_out(0, prev);
        repeat (6) begin
            step();
            check("bp_out_valid", 0, 32'(out_valid_v[0]), 32'd1);
            check("bp_diff",      0, 32'(diff_v[0]),      32'd0);
            check("bp_bo",        0, 32'(bo_v[0]),        32'd0);
            check("bp_in_ready",  0, 32'(in_ready_v[0]),  32'd0);
        end
        out_ready_v[0] = 1'b1;
        step();
        check("bp_release_in_ready",  0, 32'(in_ready_v[0]),  32'd1);
        check("bp_release_out_valid", 0, 32'(out_valid_v[0]), 32'd0);

        // Back-to-back with in_valid held high: accepts spaced WIDTH+2 edges.
        prev = 0;
        for (int k = 0; k < 8; k++) begin
            send(0, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1, acc);
            if (k > 0) check("accept_spacing", 0, 32'(acc - prev), 32'd6);
            prev = acc;
        end
        in_valid_v[0] = 1'b0;
        repeat (8) step();

        // Reset two edges into SHIFT discards the operation.
        send(0, 8'd7, 8'd1, 1'b0, 1'b0, acc);
        step();
        step();
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 0, 32'(out_valid_v[0]), 32'd0);
        check("midrst_in_ready",  0, 32'(in_ready_v[0]),  32'd1);
        check("midrst_busy",      0, 32'(busy_v[0]),      32'd0);
        step();
        rst = 1'b0;
        directed(0, 8'd5, 8'd2, 1'b0, 3, 0, "sub_5_2");

        fork
            sweep(1, 500);
            sweep(2, 500);
        join
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial ripple subtractor computing DIFF = A - B - bi over WIDTH bits. It uses one full_subtractor cell and processes one bit per clock, LSB first. It is the inverse-operation counterpart of the combinational ripple adder and sits in the datapath wherever area matters more than latency. Operands and results move over valid/ready handshakes.

Parameters:
WIDTH, 4, operand/result width in bits; legal range WIDTH >= 1.
CNT_W, max(1,$clog2(WIDTH)), bit-counter width; derived, not to be overridden.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand set valid
in_ready  output  1  block can accept operands
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
bi  input  1  borrow in
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
diff  output  WIDTH  A - B - bi, modulo 2^WIDTH
bo  output  1  borrow out; 1 when A < B + bi (unsigned)
busy  output  1  high in SHIFT or DONE

Behaviour:
- Reset (async assert, sync release): state=IDLE, out_valid=0, diff=0, bo=0, busy=0, counter=0, in_ready=1.
- in_ready = (state==IDLE). out_valid = (state==DONE). Both are decoded from registered state; no combinational path from inputs to outputs.
- IDLE: when in_valid&in_ready at an edge, capture a into a_sh, b into b_sh and bi into br; set counter=0 and go to SHIFT. a, b and bi are ignored outside this handshake.
- SHIFT, each edge:
  - d = a_sh[0]^b_sh[0]^br
  - br <= (~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&br)
  - a_sh and b_sh shift right by 1
  - diff_sh <= {d, diff_sh[WIDTH-1:1]}
  - counter++
  - when counter==WIDTH-1 on this edge: go to DONE, load diff<=final diff_sh and bo<=final br.
- DONE: diff and bo are held stable while out_valid=1. When out_ready=1 at an edge, go to IDLE.
- Latency: out_valid rises exactly WIDTH edges after the accept edge. Minimum initiation interval is WIDTH+2 edges.
- No overlap: a new operand is never accepted in SHIFT or DONE.
- WIDTH==1: a single SHIFT edge, then DONE.
- Back-pressure: DONE may persist indefinitely. The outputs must not change until the handshake completes.
- in_valid may drop before acceptance without effect. Operands present during SHIFT or DONE are not consumed.
- Reset mid-SHIFT or mid-DONE: the operation is discarded, the result is never presented, and the state is as at reset.
- diff keeps the last result after returning to IDLE. Its value is only meaningful while out_valid=1.

Decomposition:
- Shared package serial_sub_pkg: state enum (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the CNT_W derivation function.
- Sub-module full_subtractor(d, bo, a, b, bi): combinational single-bit cell, dual of full_adder, instantiated once.
- Remainder: FSM, shift registers and counter in serial_subtractor.

Test Plan:
- WIDTH=4, a=9, b=3, bi=0 -> after 4 edges out_valid=1, diff=6, bo=0.
- a=3, b=9, bi=0 -> diff=4'hA, bo=1. Also a=0, b=0, bi=1 -> diff=4'hF, bo=1.
- Back-pressure: result a=15, b=15, bi=0 (diff=0, bo=0), with out_ready=0 for 6 cycles -> out_valid, diff and bo stay stable and in_ready=0 throughout. out_ready=1 -> IDLE on the next edge.
- Back-to-back with in_valid and out_ready always high -> accepts are spaced exactly WIDTH+2=6 edges apart, and all results match a scoreboard.
- Reset asserted 2 edges into SHIFT -> out_valid=0 and in_ready=1 immediately. The next operand (a=5, b=2) yields diff=3, bo=0 with no corruption.
- WIDTH=1 and WIDTH=8 random sweep (1000 vectors) -> {bo,diff} == ({1'b0,a} - b - bi) mod 2^(WIDTH+1).
